xor5_descrambler: RTL and testbench
===================================

# xor5_descrambler

Receive-side partner of the 5-bit XOR scrambler path. It takes a stream of 5-bit scrambled words and XORs each one with a keystream from a seeded 5-bit maximal-length LFSR. Each clear word is presented on a registered valid/ready output. It sits between the scrambled-word source and the downstream consumer and must stay in lock-step with the transmit-side LFSR.

## Interface
- `WIDTH`, 5: data and LFSR width; fixed at 5, not to be overridden.
- `SEED_DEFAULT`, 5'b00001: substitute seed when an all-zero seed is loaded.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `seed_load` input 1: load `seed` into the LFSR and (re)start the run.
- `seed` input 5: keystream seed, sampled when `seed_load`=1.
- `in_valid` input 1: `in_data` holds a scrambled word.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `in_data` input 5: scrambled word.
- `out_valid` output 1: `out_data` holds a clear word.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output 5: clear word (registered).
- `key_wrap` output 1: one-cycle pulse when the 31st word since the seed load is accepted.
- `seed_err` output 1: sticky; set when a zero seed was loaded.

## Operation
- **FSM states:**
  - IDLE (reset state): unseeded; `in_ready`=0.
  - RUN: keystream active.
- **Transitions:**
  - IDLE→RUN on `seed_load`.
  - RUN→RUN on `seed_load` (re-seed).
  - There is no exit to IDLE except reset.
- **LFSR:** 5-bit Fibonacci LFSR, polynomial x^5+x^3+1, left shift: `next = {lfsr[3:0], lfsr[4]^lfsr[1]}`. Period 31.
- **Seed load:**
  - `seed_load` loads `seed`; if `seed`==0, it loads `SEED_DEFAULT` and sets `seed_err`.
- **Accept:**
  - An input word is accepted when `in_valid && in_ready`.
  - The accepted word's key is the current `lfsr` value; `out_data <= in_data ^ lfsr`.
  - On accept, `lfsr` advances one step.
- **Ready logic:** `in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready)`.
- **Output register:**
  - `out_valid` sets on accept.
  - It clears on `out_ready` when there is no new accept.
  - It stays set on simultaneous accept and `out_ready`, with the new data loaded.
- **Word counter:**
  - 5-bit `word_cnt` increments on accept.
  - When `word_cnt`==30 and an accept occurs, it wraps to 0 and pulses `key_wrap` in the next cycle.
- **Re-seed in RUN:**
  - `seed_load` has priority over everything.
  - It clears `out_valid` (any pending word is dropped), reloads `lfsr`, and clears `word_cnt`.
  - No input is accepted in that cycle.
- **Clearing `seed_err`:** cleared only by reset or by a later `seed_load` with a nonzero seed.

## Timing
- **Reset values:**
  - state=IDLE, `lfsr`=`SEED_DEFAULT`, `word_cnt`=0.
  - `out_valid`=0, `out_data`=0, `key_wrap`=0, `seed_err`=0, `in_ready`=0.
- **Latency:** 1 cycle from accept edge to `out_valid`/`out_data`.
- **Throughput:** 1 word/cycle when `out_ready` is held high.
- **Back-pressure:** while `out_valid && !out_ready`, `out_data` holds stable and `in_ready`=0.
- **First accept after seeding:** `in_ready` rises the cycle after `seed_load`. The first accepted word uses the seed itself as its key.
- **Reset mid-stream:** asynchronous; outputs are at reset values immediately, and the pending word is lost.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready` and `seed_load`. There is no other combinational input-to-output path.

## Structure
- **Package `xor5_pkg`:**
  - `WIDTH`=5, `LFSR_TAP_HI`=4, `LFSR_TAP_LO`=1, `SEED_DEFAULT`.
  - State enum (`ST_IDLE`, `ST_RUN`).
  - `KEY_PERIOD`=31.
- **Sub-module `lfsr5`:**
  - Inputs: `clk`, `rst_n`, `load`, `load_val`, `step`.
  - Output: `q`.
  - Holds the polynomial and zero-seed substitution; reused by the transmit-side scrambler.
- **Top level:** FSM, handshake, output register, counter, flags.

## Test plan
1. **Reset and idle:** assert `rst_n`=0 mid-cycle, then release → all outputs at reset values; with `in_valid`=1 in IDLE, `in_ready` stays 0.
2. **Basic decode:**
   - Stimulus: seed 5'b00001, `out_ready`=1, inputs 00010, 11100, 00101.
   - Required outputs on consecutive cycles: 00011, 11110, 00000 (keys 00001, 00010, 00101).
3. **Back-pressure:** same seed; first word 10101 accepted, then `out_ready`=0 for 3 cycles → `out_data`=10100 held stable, `in_ready`=0, and `lfsr` does not advance past 00010.
4. **Zero seed:** `seed_load` with 00000 → `seed_err`=1; the first decode of 11111 gives 11110.
5. **Wrap:** seed 00001, 31 back-to-back words of 00000 → `out_data` walks the full 31-state sequence; `key_wrap` pulses once; word 32 decodes with key 00001 again.
6. **Re-seed mid-stream:** with `out_valid`=1 and `out_ready`=0, pulse `seed_load` with seed 01010 together with `in_valid` → `out_valid` clears, no accept occurs, and the next word 01010 decodes to 00000.

Source files
------------

// File: rtl/xor5_pkg.sv
// xor5_pkg: shared widths, LFSR taps, seed default and FSM states for the 5-bit XOR scrambler path
package xor5_pkg;
    localparam int WIDTH = 5;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 1;
    localparam logic [WIDTH-1:0] SEED_DEFAULT = 5'b00001;
    localparam int KEY_PERIOD = 31;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/lfsr5.sv
// lfsr5: seedable x^5+x^3+1 Fibonacci LFSR; a zero seed is replaced so the register never locks up
module lfsr5 #(
    parameter logic [xor5_pkg::WIDTH-1:0] SEED_DEFAULT = xor5_pkg::SEED_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [xor5_pkg::WIDTH-1:0] load_val,
    input  logic                       step,
    output logic [xor5_pkg::WIDTH-1:0] q
);
    import xor5_pkg::*;
    logic [WIDTH-1:0] q_q, q_d;
    always_comb
        q_d = load ? ((load_val == '0) ? SEED_DEFAULT : load_val)
            : step ? {q_q[WIDTH-2:0], q_q[LFSR_TAP_HI] ^ q_q[LFSR_TAP_LO]}
            : q_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= SEED_DEFAULT;
        else        q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/xor5_descrambler.sv
// xor5_descrambler: XORs each accepted 5-bit word with an LFSR keystream behind a registered valid/ready output
module xor5_descrambler #(
    parameter int                  WIDTH        = xor5_pkg::WIDTH,
    parameter logic [WIDTH-1:0]    SEED_DEFAULT = xor5_pkg::SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             key_wrap,
    output logic             seed_err
);
    import xor5_pkg::*;
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d, key_wrap_q, key_wrap_d, seed_err_q, seed_err_d;
    logic [WIDTH-1:0] out_data_q, out_data_d, key;
    logic [4:0]       word_cnt_q, word_cnt_d;
    logic             accept, last_word;

    lfsr5 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (seed),
        .step     (accept),
        .q        (key)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;

    always_comb state_d = seed_load ? ST_RUN : state_q;

    always_comb in_ready = (state_q == ST_RUN) && !seed_load && (!out_valid_q || out_ready);

    assign accept    = in_valid && in_ready;
    assign last_word = word_cnt_q == 5'(KEY_PERIOD - 1);

    // seed_load wins: drops any pending word and restarts the count; accept is already blocked
    always_comb begin
        out_valid_d = seed_load ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
        out_data_d  = accept ? in_data ^ key : out_data_q;
        word_cnt_d  = seed_load ? 5'd0 : accept ? (last_word ? 5'd0 : word_cnt_q + 5'd1) : word_cnt_q;
        key_wrap_d  = accept && last_word;
        seed_err_d  = seed_load ? (seed == '0) : seed_err_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
            key_wrap_q  <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
            key_wrap_q  <= key_wrap_d;
            seed_err_q  <= seed_err_d;
        end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign key_wrap  = key_wrap_q;
    assign seed_err  = seed_err_q;
endmodule

// File: tb/tb_xor5_descrambler.sv
// tb_xor5_descrambler: directed and random checks against a keystream-position model of the descrambler
module tb_xor5_descrambler;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       seed_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [4:0] seed = '0, in_data = '0;
    logic       in_ready, out_valid, key_wrap, seed_err;
    logic [4:0] out_data;

    xor5_descrambler dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_wrap(key_wrap), .seed_err(seed_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, wraps = 0;
    logic [4:0] seq [31];
    bit         m_run, m_ov, m_err, m_wrap;
    logic [4:0] m_od;
    int         m_base, m_n;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input logic [4:0] v);
        for (int i = 0; i < 31; i++) if (seq[i] == v) return i;
        return 0;
    endfunction

    task automatic chk_outs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".out_data"}, out_data, m_od);
        chk({tag, ".key_wrap"}, key_wrap, m_wrap);
        chk({tag, ".seed_err"}, seed_err, m_err);
    endtask

    task automatic step(input string tag, input logic sl, input logic [4:0] sd,
                        input logic iv, input logic [4:0] id, input logic ordy);
        logic er, acc;
        seed_load = sl; seed = sd; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        er = m_run && !sl && (!m_ov || ordy);
        chk({tag, ".in_ready"}, in_ready, er);
        acc = iv && er;
        if (sl) begin
            m_run = 1; m_err = (sd == 0); m_base = pos_of(sd == 0 ? 5'd1 : sd);
            m_n = 0; m_ov = 0; m_wrap = 0;
        end else begin
            m_wrap = acc && (m_n % 31 == 30);
            if (acc) begin
                m_od = id ^ seq[(m_base + m_n) % 31];
                m_ov = 1;
                m_n++;
            end else if (ordy) m_ov = 0;
        end
        @(posedge clk); #1;
        chk_outs(tag);
        wraps += int'(key_wrap);
    endtask

    task automatic reset_mid(input string tag);
        @(posedge clk); #3;
        rst_n = 1'b0;
        m_run = 0; m_ov = 0; m_od = 0; m_err = 0; m_wrap = 0;
        #1;
        chk_outs(tag);
        chk({tag, ".in_ready"}, in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] v;
        v = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            seq[i] = v;
            v = {v[3:0], v[4] ^ v[1]};
        end
        #12;
        reset_mid("reset");
        step("idle", 0, 0, 1, 5'b10110, 1);

        step("basic_seed", 1, 5'b00001, 0, 0, 1);
        step("basic_w0", 0, 0, 1, 5'b00010, 1);
        chk("basic_w0_const", out_data, 5'b00011);
        step("basic_w1", 0, 0, 1, 5'b11100, 1);
        chk("basic_w1_const", out_data, 5'b11110);
        step("basic_w2", 0, 0, 1, 5'b00101, 1);
        chk("basic_w2_const", out_data, 5'b00000);

        step("bp_seed", 1, 5'b00001, 0, 0, 1);
        step("bp_w0", 0, 0, 1, 5'b10101, 0);
        for (int i = 0; i < 3; i++) begin
            step("bp_hold", 0, 0, 1, 5'($urandom), 0);
            chk("bp_hold_const", out_data, 5'b10100);
        end
        step("bp_w1", 0, 0, 1, 5'b00000, 1);
        chk("bp_key_const", out_data, 5'b00010);

        step("zero_seed", 1, 5'b00000, 0, 0, 1);
        chk("zero_err_const", seed_err, 1'b1);
        step("zero_w0", 0, 0, 1, 5'b11111, 1);
        chk("zero_w0_const", out_data, 5'b11110);
        step("err_clear", 1, 5'b00001, 0, 0, 1);

        wraps = 0;
        for (int i = 0; i < 31; i++) step("wrap", 0, 0, 1, 5'b00000, 1);
        step("wrap_w32", 0, 0, 1, 5'b00000, 1);
        chk("wrap_w32_const", out_data, 5'b00001);
        chk("wrap_count", 5'(wraps), 5'd1);

        step("rs_w0", 0, 0, 1, 5'b01100, 0);
        step("rs_load", 1, 5'b01010, 1, 5'b11111, 0);
        chk("rs_valid_const", out_valid, 1'b0);
        step("rs_w1", 0, 0, 1, 5'b01010, 1);
        chk("rs_w1_const", out_data, 5'b00000);

        step("mid_w", 0, 0, 1, 5'($urandom), 0);
        reset_mid("mid_reset");
        step("mid_idle", 0, 0, 1, 5'($urandom), 1);

        for (int i = 0; i < 600; i++) begin
            logic sl;
            logic [4:0] sd;
            sl = (i == 0) || ($urandom_range(0, 24) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step("rand", sl, sd, 1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 2) != 0));
            if (i == 300) reset_mid("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
